ultrasonic_scheduler: RTL

//  Round-robin controller that shares one echo-timing datapath among NUM_SENSORS HC-SR04-style rangers.

---
 rtl/ultrasonic_scheduler.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ultrasonic_scheduler.sv
// Round-robin HC-SR04 ranger scheduler: fires one trigger at a time, resyncs the
// selected echo, measures its high time in clock ticks and spaces pings by a gap.
module ultrasonic_scheduler #(
    parameter int unsigned NUM_SENSORS    = 3,
    parameter int unsigned CH_W           = 2,
    parameter int unsigned CNT_W          = 23,
    parameter int unsigned TRIG_CYCLES    = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 3000000,
    parameter int unsigned GAP_CYCLES     = 6000000
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [NUM_SENSORS-1:0] echo,
    output logic [NUM_SENSORS-1:0] trig,
    output logic [CNT_W-1:0]       dist_ticks,
    output logic [CH_W-1:0]        dist_ch,
    output logic                   dist_valid,
    output logic                   dist_timeout,
    output logic                   busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_GAP
    } state_t;

    localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LIM  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CH_W-1:0]  CH_LAST      = CH_W'(NUM_SENSORS - 1);

    state_t                   state, state_d;
    logic [CNT_W-1:0]         cnt, cnt_d;
    logic [CH_W-1:0]          cur, cur_d;
    logic [NUM_SENSORS-1:0]   resync1, resync2, resync3;
    logic [NUM_SENSORS-1:0]   rise_q, fall_q;
    logic                     report, rep_timeout;
    logic [NUM_SENSORS-1:0]   trig_d;
    logic                     busy_d;
    logic [CNT_W-1:0]         ticks_d;

    // Echo lines are asynchronous; edges are registered after the resync chain.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            resync1 <= '0;
            resync2 <= '0;
            resync3 <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            resync1 <= echo;
            resync2 <= resync1;
            resync3 <= resync2;
            rise_q  <= resync2 & ~resync3;
            fall_q  <= resync3 & ~resync2;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            cur          <= '0;
            trig         <= '0;
            busy         <= 1'b0;
            dist_ticks   <= '0;
            dist_ch      <= '0;
            dist_valid   <= 1'b0;
            dist_timeout <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            cur        <= cur_d;
            trig       <= trig_d;
            busy       <= busy_d;
            dist_valid <= report;
            if (report) begin
                dist_ticks   <= ticks_d;
                dist_ch      <= cur;
                dist_timeout <= rep_timeout;
            end
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        cur_d       = cur;
        report      = 1'b0;
        rep_timeout = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_TRIG;
                    cnt_d   = '0;
                end
            end
            S_TRIG: begin
                if (cnt == TRIG_LAST) begin
                    state_d = S_WAIT_RISE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_WAIT_RISE: begin
                if (rise_q[cur]) begin
                    state_d = S_MEASURE;
                    cnt_d   = CNT_W'(1);
                end else if (cnt == TIMEOUT_LAST) begin
                    state_d     = S_GAP;
                    cnt_d       = '0;
                    report      = 1'b1;
                    rep_timeout = 1'b1;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_MEASURE: begin
                if (fall_q[cur]) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                    report  = 1'b1;
                end else if (cnt == TIMEOUT_LIM) begin
                    state_d     = S_GAP;
                    cnt_d       = '0;
                    report      = 1'b1;
                    rep_timeout = 1'b1;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_d   = '0;
                    cur_d   = (cur == CH_LAST) ? '0 : cur + CH_W'(1);
                    state_d = enable ? S_TRIG : S_IDLE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are derived from the next state so the registered copies line up with it.
    always_comb begin
        trig_d = '0;
        if (state_d == S_TRIG)
            trig_d = NUM_SENSORS'(1) << cur_d;
        busy_d  = (state_d != S_IDLE);
        ticks_d = rep_timeout ? TIMEOUT_LIM : cnt;
    end

endmodule
